uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between the game's event transmitters: end-of-game, board-update, score and similar frame senders. Each requester holds a level request for the duration of a multi-byte frame. The arbiter grants exactly one owner at a time using round-robin priority and forwards that owner's bytes to the UART one at a time. It returns per-requester busy and byte-sent handshakes, so each requester sees what looks like a private UART.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 50000: idle-owner timeout in clk cycles, 16-bit. Used only when TX_ARB_TIMEOUT_EN is defined.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  level request per requester; held high for the whole frame.
- send_i  in  N_REQ  one-cycle byte strobe per requester.
- data_i  in  8*N_REQ  byte per requester; requester k uses bits [8k+7:8k].
- grant_o  out  N_REQ  one-hot current owner, registered.
- tx_busy_o  out  N_REQ  busy view per requester.
- data_sent_o  out  N_REQ  one-cycle pulse to the owner when its byte finishes.
- timeout_o  out  1  one-cycle pulse on forced release.
- uart_start_o  out  1  one-cycle start strobe to the UART.
- uart_data_o  out  8  byte to the UART, registered.
- uart_busy_i  in  1  UART busy.
- uart_done_i  in  1  UART byte-complete pulse.

## Operation
- States: IDLE, OWNED, SENDING.
- Reset (reset_n=0): state IDLE, grant_o=0, uart_start_o=0, uart_data_o=8'h00, data_sent_o=0, timeout_o=0, last_owner=N_REQ-1, internal mask=0. Reset mid-frame aborts the frame with no data_sent_o pulse.
- IDLE: if any unmasked req_i bit is high, pick the first one searching upward from last_owner+1 with wrap-around. Set grant_o to that bit and go to OWNED.
- OWNED:
  - If the owner's req_i is low: clear grant_o, set last_owner to the owner, go to IDLE.
  - Else if the owner's send_i=1 and uart_busy_i=0: latch the owner's byte into uart_data_o, pulse uart_start_o, go to SENDING.
  - send_i from a non-owner is ignored and dropped.
- SENDING:
  - On uart_done_i: pulse the owner's data_sent_o bit.
  - Then go to OWNED if the owner's req_i is still high, else release (clear grant_o, update last_owner) and go to IDLE.
  - If req_i drops during SENDING, the current byte still completes before release.
- tx_busy_o[k] = 1 when k is not the owner. For the owner it equals (state != OWNED) or uart_busy_i. This is combinational from state and uart_busy_i.
- Round-robin guarantee: a continuously requesting requester is granted within N_REQ-1 frames.

## Timing
- Request to grant: 1 cycle from IDLE. At least one IDLE cycle between consecutive frames.
- Owner send_i to uart_start_o: 1 cycle. uart_data_o is valid in the same cycle as uart_start_o and holds until the next start.
- uart_done_i to data_sent_o: 1 cycle. If the owner keeps its request, it can send its next byte in the cycle after data_sent_o.
- uart_done_i and a req_i drop in the same cycle: data_sent_o still pulses, then the grant is released.
- uart_start_o is never asserted while uart_busy_i=1.

## Configuration
- TX_ARB_TIMEOUT_EN defined:
  - A 16-bit counter runs in OWNED, clears on each accepted send, and holds in SENDING.
  - When it reaches TIMEOUT_CYCLES: pulse timeout_o, release the owner, and set the owner's mask bit.
  - A mask bit clears when that requester drops req_i.
- TX_ARB_TIMEOUT_EN undefined: no counter, timeout_o tied 0, mask always 0, and an owner holds the grant indefinitely.

## Test plan
- Single frame: requester 0 holds req and sends 8'hAE then 8'h10. Required: uart_data_o shows AE then 10, two data_sent_o[0] pulses, and grant_o returns to 0 one cycle after req drops.
- Contention: req_i=4'b1111 held from reset. Required: grant order 0,1,2,3,0, with one two-byte frame per requester.
- Non-owner send: requester 2 pulses send_i with 8'h55 while requester 1 owns the UART. Required: no uart_start_o, and tx_busy_o[2]=1 throughout.
- Late release: requester 0 drops req_i in the same cycle as uart_done_i. Required: data_sent_o[0] pulses, and requester 1 (pending) is granted two cycles later.
- Reset mid-byte: assert reset_n=0 during SENDING. Required: all outputs return to reset values immediately, and no data_sent_o pulse occurs.
- Timeout (macro on, TIMEOUT_CYCLES=10): owner 3 holds req with no sends. Required: timeout_o pulses at cycle 10 of OWNED, grant moves to the next requester, and requester 3 is not regranted until its req_i drops and rises again.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the frame senders, the shared UART and uart_tx_arbiter.
// Handshakes: req_i[k] is a level held for a whole frame. send_i[k] is a
// one-cycle byte strobe that is accepted only while tx_busy_o[k] is 0.
// data_sent_o[k] pulses once per accepted byte when the UART finishes it.
// uart_start_o is a one-cycle strobe, issued only while uart_busy_i is 0.
// uart_done_i is a one-cycle completion pulse from the UART.
// arb_state exposes the arbiter FSM state for observation.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req_i;
  logic [N_REQ-1:0]   send_i;
  logic [8*N_REQ-1:0] data_i;
  logic [N_REQ-1:0]   grant_o;
  logic [N_REQ-1:0]   tx_busy_o;
  logic [N_REQ-1:0]   data_sent_o;
  logic               timeout_o;
  logic               uart_start_o;
  logic [7:0]         uart_data_o;
  logic               uart_busy_i;
  logic               uart_done_i;
  logic [1:0]         arb_state;

  modport slave (
    input  req_i, send_i, data_i, uart_busy_i, uart_done_i,
    output grant_o, tx_busy_o, data_sent_o, timeout_o, uart_start_o,
           uart_data_o, arb_state
  );

  modport master (
    output req_i, send_i, data_i, uart_busy_i, uart_done_i,
    input  grant_o, tx_busy_o, data_sent_o, timeout_o, uart_start_o,
           uart_data_o, arb_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner arbiter in front of a single UART transmitter.
// One requester owns the UART for a whole frame; its bytes are forwarded
// one at a time and every requester sees a private-looking busy/sent pair.
// Optional feature macro: TX_ARB_TIMEOUT_EN enables the idle-owner timeout
// (forced release plus a per-requester mask until its request drops).
module uart_tx_arbiter #(
  parameter int          N_REQ          = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input logic              clk,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWNED   = 2'd1;
  localparam logic [1:0] ST_SENDING = 2'd2;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

  logic [1:0]       state;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] sent;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] avail;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             pick_valid;
  logic             start;
  logic [7:0]       udata;
  logic [7:0]       owner_byte;
  logic             owner_req;
  logic             owner_send;
  logic             accept;
  logic             tmo_hit;
  logic             timeout;
  int               cand;

  // Masked requesters are invisible to the search; the owner's own
  // request, strobe and byte are selected through the one-hot grant.
  assign avail       = bus.req_i & ~mask;
  assign owner_req   = |(bus.req_i & grant);
  assign owner_send  = |(bus.send_i & grant);
  assign accept      = (state == ST_OWNED) && owner_req && owner_send && !bus.uart_busy_i;
  assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

  // Select the current owner's byte lane.
  always_comb begin
    owner_byte = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) owner_byte = bus.data_i[8*k +: 8];
    end
  end

  // Round-robin search starting just after last_owner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last_owner) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!pick_valid && avail[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Ownership FSM: grant, byte forwarding and release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= LAST_RESET;
      start      <= 1'b0;
      udata      <= 8'h00;
      sent       <= '0;
    end else begin
      start <= 1'b0;
      sent  <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick_onehot;
            owner <= pick_idx;
            state <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (!owner_req || tmo_hit) begin
            grant      <= '0;
            last_owner <= owner;
            state      <= ST_IDLE;
          end else if (accept) begin
            udata <= owner_byte;
            start <= 1'b1;
            state <= ST_SENDING;
          end
        end
        ST_SENDING: begin
          // A request dropped mid-byte is honoured only once the byte is out.
          if (bus.uart_done_i) begin
            sent <= grant;
            if (owner_req) begin
              state <= ST_OWNED;
            end else begin
              grant      <= '0;
              last_owner <= owner;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (state == ST_OWNED) && owner_req && !accept &&
                   (tmo_cnt == TIMEOUT_CYCLES - 16'd1);

  // Idle-owner counter, timeout pulse and the mask that blocks re-grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
      mask    <= '0;
    end else begin
      timeout <= tmo_hit;
      mask    <= (mask & bus.req_i) | (tmo_hit ? grant : '0);
      if (state == ST_IDLE || accept || tmo_hit) begin
        tmo_cnt <= '0;
      end else if (state == ST_OWNED) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_cfg;
  assign tmo_hit    = 1'b0;
  assign timeout    = 1'b0;
  assign mask       = '0;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  // Non-owners always look busy; the owner is free only while OWNED and idle UART.
  assign bus.tx_busy_o    = ~grant | {N_REQ{(state != ST_OWNED) || bus.uart_busy_i}};
  assign bus.grant_o      = grant;
  assign bus.data_sent_o  = sent;
  assign bus.timeout_o    = timeout;
  assign bus.uart_start_o = start;
  assign bus.uart_data_o  = udata;
  assign bus.arb_state    = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: UART model, byte scoreboard, scenario tasks.
module tb_uart_tx_arbiter;
  localparam int N_REQ = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   uart_len = 3;
  int   ucnt     = 0;
  int   sent_cnt [N_REQ];
  logic [7:0] exp_q[$];
  int   exp_owner_q[$];

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYCLES(16'd10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // UART model: busy for uart_len cycles after a start, then a done pulse.
  initial begin
    bus.uart_busy_i = 1'b0;
    bus.uart_done_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.uart_done_i = 1'b0;
      if (!reset_n) begin
        bus.uart_busy_i = 1'b0;
        ucnt = 0;
      end else begin
        if (bus.uart_start_o) begin
          n_checks++;
          if (bus.uart_busy_i !== 1'b0) $display("FAIL start_while_busy: busy=%b required 0", bus.uart_busy_i);
          else n_pass++;
        end
        if (bus.uart_busy_i) begin
          if (ucnt <= 1) begin
            bus.uart_busy_i = 1'b0;
            bus.uart_done_i = 1'b1;
          end else begin
            ucnt--;
          end
        end else if (bus.uart_start_o) begin
          bus.uart_busy_i = 1'b1;
          ucnt = uart_len;
        end
      end
    end
  end

  // Scoreboard monitor: every start must carry the next expected byte.
  initial begin
    logic [7:0] e;
    for (int k = 0; k < N_REQ; k++) sent_cnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N_REQ; k++) if (bus.data_sent_o[k] === 1'b1) sent_cnt[k]++;
      if (bus.uart_start_o === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_start: data=%h with empty expected queue", bus.uart_data_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.uart_data_o !== e) $display("FAIL uart_data: got %h required %h", bus.uart_data_o, e);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int k, input string name);
    for (int i = 0; i < 20 && bus.grant_o[k] !== 1'b1; i++) tick();
    n_checks++;
    if (bus.grant_o[k] !== 1'b1) $display("FAIL %s: grant=%b never reached requester %0d", name, bus.grant_o, k);
    else n_pass++;
  endtask

  // Owner k sends one byte and waits for its data_sent pulse.
  task automatic send_byte(input int k, input logic [7:0] b);
    logic [3:0] onehot;
    onehot = 4'b0001 << k;
    for (int i = 0; i < 20 && bus.tx_busy_o[k] !== 1'b0; i++) tick();
    n_checks++;
    if (bus.tx_busy_o[k] !== 1'b0) begin
      $display("FAIL send_ready_%0d: tx_busy=%b required bit clear", k, bus.tx_busy_o);
      return;
    end
    n_pass++;
    bus.send_i[k] = 1'b1;
    bus.data_i[8*k +: 8] = b;
    exp_q.push_back(b);
    tick();
    bus.send_i[k] = 1'b0;
    for (int i = 0; i < 60 && bus.data_sent_o[k] !== 1'b1; i++) tick();
    n_checks++;
    if (bus.data_sent_o !== onehot) $display("FAIL data_sent_%0d: got %b required %b", k, bus.data_sent_o, onehot);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.grant_o !== 4'b0000) $display("FAIL rst_grant: got %b required 0000", bus.grant_o); else n_pass++;
    n_checks++; if (bus.uart_start_o !== 1'b0) $display("FAIL rst_start: got %b required 0", bus.uart_start_o); else n_pass++;
    n_checks++; if (bus.uart_data_o !== 8'h00) $display("FAIL rst_data: got %h required 00", bus.uart_data_o); else n_pass++;
    n_checks++; if (bus.data_sent_o !== 4'b0000) $display("FAIL rst_sent: got %b required 0000", bus.data_sent_o); else n_pass++;
    n_checks++; if (bus.timeout_o !== 1'b0) $display("FAIL rst_timeout: got %b required 0", bus.timeout_o); else n_pass++;
    n_checks++; if (bus.tx_busy_o !== 4'b1111) $display("FAIL rst_busy: got %b required 1111", bus.tx_busy_o); else n_pass++;
    n_checks++; if (bus.arb_state !== 2'd0) $display("FAIL rst_state: got %0d required 0", bus.arb_state); else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    bus.req_i[0] = 1'b1;
    tick();
    n_checks++; if (bus.grant_o !== 4'b0001) $display("FAIL single_grant: got %b required 0001", bus.grant_o); else n_pass++;
    send_byte(0, 8'hAE);
    n_checks++; if (bus.uart_data_o !== 8'hAE) $display("FAIL single_hold_ae: got %h required ae", bus.uart_data_o); else n_pass++;
    send_byte(0, 8'h10);
    bus.req_i[0] = 1'b0;
    tick();
    n_checks++; if (bus.grant_o !== 4'b0000) $display("FAIL single_release: got %b required 0000", bus.grant_o); else n_pass++;
    n_checks++; if (bus.uart_data_o !== 8'h10) $display("FAIL single_hold_10: got %h required 10", bus.uart_data_o); else n_pass++;
    n_checks++; if (sent_cnt[0] !== 2) $display("FAIL single_sent_count: got %0d required 2", sent_cnt[0]); else n_pass++;
  endtask

  task automatic test_non_owner();
    bus.req_i[1] = 1'b1;
    wait_grant(1, "nonowner_grant");
    bus.send_i[2] = 1'b1;
    bus.data_i[23:16] = 8'h55;
    tick();
    bus.send_i[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.uart_start_o !== 1'b0) $display("FAIL nonowner_start: got %b required 0", bus.uart_start_o); else n_pass++;
      n_checks++; if (bus.tx_busy_o[2] !== 1'b1) $display("FAIL nonowner_busy2: got %b required 1", bus.tx_busy_o[2]); else n_pass++;
      n_checks++; if (bus.tx_busy_o[1] !== 1'b0) $display("FAIL owner_free: got %b required 0", bus.tx_busy_o[1]); else n_pass++;
      tick();
    end
    send_byte(1, 8'h3C);
    n_checks++; if (bus.tx_busy_o[2] !== 1'b1) $display("FAIL nonowner_busy2_after: got %b required 1", bus.tx_busy_o[2]); else n_pass++;
    bus.req_i[1] = 1'b0;
    tick();
  endtask

  task automatic test_late_release();
    bus.req_i[0] = 1'b1;
    bus.req_i[1] = 1'b1;
    tick();
    n_checks++; if (bus.grant_o !== 4'b0001) $display("FAIL late_grant0: got %b required 0001", bus.grant_o); else n_pass++;
    bus.send_i[0] = 1'b1;
    bus.data_i[7:0] = 8'hC3;
    exp_q.push_back(8'hC3);
    tick();
    bus.send_i[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.uart_done_i === 1'b1) break;
    end
    n_checks++; if (bus.uart_done_i !== 1'b1) $display("FAIL late_done_seen: got %b required 1", bus.uart_done_i); else n_pass++;
    bus.req_i[0] = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.data_sent_o !== 4'b0001) $display("FAIL late_sent: got %b required 0001", bus.data_sent_o); else n_pass++;
    n_checks++; if (bus.grant_o !== 4'b0000) $display("FAIL late_release: got %b required 0000", bus.grant_o); else n_pass++;
    tick();
    n_checks++; if (bus.grant_o !== 4'b0010) $display("FAIL late_grant1: got %b required 0010", bus.grant_o); else n_pass++;
    bus.req_i[1] = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int k;
    int e;
    logic [3:0] onehot;
    reset_n = 1'b0;
    bus.req_i = 4'b1111;
    tick();
    tick();
    reset_n = 1'b1;
    exp_owner_q = '{0, 1, 2, 3, 0};
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 20 && bus.grant_o === 4'b0000; i++) tick();
      e = exp_owner_q.pop_front();
      onehot = 4'b0001 << e;
      n_checks++;
      if (bus.grant_o !== onehot) $display("FAIL rr_order_%0d: got %b required %b", f, bus.grant_o, onehot);
      else n_pass++;
      k = e;
      for (int j = 0; j < N_REQ; j++) if (bus.grant_o[j] === 1'b1) k = j;
      send_byte(k, 8'($urandom_range(0, 255)));
      send_byte(k, 8'($urandom_range(0, 255)));
      if (f < 4) begin
        bus.req_i[k] = 1'b0;
        tick();
        n_checks++; if (bus.grant_o !== 4'b0000) $display("FAIL rr_gap_%0d: got %b required 0000", f, bus.grant_o); else n_pass++;
        bus.req_i[k] = 1'b1;
      end else begin
        bus.req_i = 4'b0000;
        tick();
      end
    end
    tick();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL rr_queue_empty: got %0d required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_byte();
    int s;
    bus.req_i[2] = 1'b1;
    wait_grant(2, "midrst_grant");
    uart_len = 20;
    bus.send_i[2] = 1'b1;
    bus.data_i[23:16] = 8'h9A;
    exp_q.push_back(8'h9A);
    tick();
    bus.send_i[2] = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.arb_state !== 2'd2) $display("FAIL midrst_sending: got %0d required 2", bus.arb_state); else n_pass++;
    s = sent_cnt[2];
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.grant_o !== 4'b0000) $display("FAIL midrst_grant0: got %b required 0000", bus.grant_o); else n_pass++;
    n_checks++; if (bus.uart_data_o !== 8'h00) $display("FAIL midrst_data: got %h required 00", bus.uart_data_o); else n_pass++;
    n_checks++; if (bus.arb_state !== 2'd0) $display("FAIL midrst_state: got %0d required 0", bus.arb_state); else n_pass++;
    n_checks++; if (bus.tx_busy_o !== 4'b1111) $display("FAIL midrst_busy: got %b required 1111", bus.tx_busy_o); else n_pass++;
    n_checks++; if ({bus.uart_start_o, bus.data_sent_o, bus.timeout_o} !== 6'b0) $display("FAIL midrst_pulses: got %b required 000000", {bus.uart_start_o, bus.data_sent_o, bus.timeout_o}); else n_pass++;
    bus.req_i[2] = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    n_checks++; if (sent_cnt[2] !== s) $display("FAIL midrst_no_sent: got %0d required %0d", sent_cnt[2], s); else n_pass++;
    uart_len = 3;
  endtask

`ifdef TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req_i[3] = 1'b1;
    tick();
    n_checks++; if (bus.grant_o !== 4'b1000) $display("FAIL tmo_grant3: got %b required 1000", bus.grant_o); else n_pass++;
    bus.req_i[0] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_checks++;
      if ({bus.timeout_o, bus.grant_o} !== 5'b01000) $display("FAIL tmo_early_%0d: got %b required 01000", i, {bus.timeout_o, bus.grant_o});
      else n_pass++;
    end
    tick();
    n_checks++; if ({bus.timeout_o, bus.grant_o} !== 5'b10000) $display("FAIL tmo_pulse: got %b required 10000", {bus.timeout_o, bus.grant_o}); else n_pass++;
    tick();
    n_checks++; if ({bus.timeout_o, bus.grant_o} !== 5'b00001) $display("FAIL tmo_next_owner: got %b required 00001", {bus.timeout_o, bus.grant_o}); else n_pass++;
    bus.req_i[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.grant_o !== 4'b0000) $display("FAIL tmo_masked: got %b required 0000", bus.grant_o); else n_pass++;
    end
    bus.req_i[3] = 1'b0;
    tick();
    bus.req_i[3] = 1'b1;
    tick();
    n_checks++; if (bus.grant_o !== 4'b1000) $display("FAIL tmo_regrant: got %b required 1000", bus.grant_o); else n_pass++;
    bus.req_i[3] = 1'b0;
    tick();
    tick();
  endtask
`else
  task automatic test_timeout();
    bus.req_i[3] = 1'b1;
    tick();
    n_checks++; if (bus.grant_o !== 4'b1000) $display("FAIL hold_grant3: got %b required 1000", bus.grant_o); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if ({bus.timeout_o, bus.grant_o} !== 5'b01000) $display("FAIL hold_%0d: got %b required 01000", i, {bus.timeout_o, bus.grant_o});
      else n_pass++;
    end
    bus.req_i[3] = 1'b0;
    tick();
    tick();
  endtask
`endif

  // Scenario sequence and final report.
  initial begin
    reset_n    = 1'b0;
    bus.req_i  = '0;
    bus.send_i = '0;
    bus.data_i = '0;
    test_reset();
    test_single_frame();
    test_non_owner();
    test_late_release();
    test_contention();
    test_reset_mid_byte();
    test_timeout();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL final_queue: got %0d entries required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
